// File: rtl/mips_inst_encoder.sv
// rtl/mips_inst_encoder.sv - MIPS instruction encoder and imem loader; MIPS_ENC_BYTE_ADDR_EN selects byte addressing
// Encodes instruction fields into 32-bit words, queues them, and writes them to sequential imem addresses.
module mips_inst_encoder #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        in_kind,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        shamt,
   input  logic [5:0]        funct,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   input  logic              imem_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam int PW = $clog2(DEPTH);
`ifdef MIPS_ENC_BYTE_ADDR_EN
   localparam int STEP = 4;
`else
   localparam int STEP = 1;
`endif

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [31:0]       mem [DEPTH];
   logic [PW:0]       wr_ptr, rd_ptr;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] base_eff;
   logic [ADDR_W:0]   addr_sum;
   logic [31:0]       enc_word;
   logic              enc_ok;
   logic              fifo_empty, fifo_full;
   logic              accept, push, pop;

`ifdef MIPS_ENC_BYTE_ADDR_EN
   assign base_eff = {base_addr[ADDR_W-1:2], 2'b00};
`else
   assign base_eff = base_addr;
`endif

   always_comb begin
      enc_word = '0;
      enc_ok   = 1'b1;
      case (in_kind)
         3'd0:    enc_word = {6'b000000, rs, rt, rd, shamt, funct};
         3'd1:    enc_word = {6'b100011, rs, rt, imm};
         3'd2:    enc_word = {6'b101011, rs, rt, imm};
         3'd3:    enc_word = {6'b000100, rs, rt, imm};
         3'd4:    enc_word = {6'b001000, rs, rt, imm};
         3'd5:    enc_word = {6'b001101, rs, rt, imm};
         3'd6:    enc_word = {6'b000010, target};
         default: enc_ok   = 1'b0;
      endcase
   end

   // Full when pointers differ only in the wrap bit.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

   assign in_ready   = (state == S_LOAD) && !fifo_full;
   assign accept     = in_valid && in_ready;
   assign push       = accept && enc_ok;
   assign imem_we    = !fifo_empty;
   assign pop        = imem_we && imem_ready;
   assign imem_addr  = addr;
   assign imem_wdata = fifo_empty ? 32'd0 : mem[rd_ptr[PW-1:0]];
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);
   assign addr_sum   = {1'b0, addr} + (ADDR_W+1)'(STEP);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PW-1:0]] <= enc_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         addr   <= '0;
         err    <= 1'b0;
         count  <= '0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
         if (state == S_IDLE && start) begin
            addr  <= base_eff;
            count <= '0;
            err   <= 1'b0;
         end else begin
            if (pop) begin
               addr <= addr_sum[ADDR_W-1:0];
               if (count != '1) count <= count + (ADDR_W+1)'(1);
               if (addr_sum[ADDR_W]) err <= 1'b1;
            end
            if (accept && !enc_ok) err <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  if (accept && in_last) state_nxt = S_FLUSH;
         S_FLUSH: if (fifo_empty) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
